// File: rtl/shiftout_arbiter.sv
// Round-robin arbiter sharing one shiftout serializer between N_REQ requesters.
// The engine has no busy flag, so each transfer is held for a fixed SHIFT_CYCLES guard time.
module shiftout_arbiter #(
    parameter int WIDTH        = 16,
    parameter int N_REQ        = 4,
    parameter int GW           = 2,
    parameter int SHIFT_CYCLES = 40
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] data_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic                   busy_o,
    output logic [GW-1:0]          grant_o,
    output logic [WIDTH-1:0]       shift_data_o,
    output logic                   shift_rdy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STROBE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;
    localparam int CW = $clog2(SHIFT_CYCLES + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] last;
    logic          found;
    logic [GW-1:0] pick;

    // Search starts one past the last served requester, so it gets lowest priority next.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && req_i[(int'(last) + i) % N_REQ]) begin
                found = 1'b1;
                pick  = GW'((int'(last) + i) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            last         <= GW'(N_REQ - 1);
            ack_o        <= '0;
            busy_o       <= 1'b0;
            grant_o      <= '0;
            shift_data_o <= '0;
            shift_rdy_o  <= 1'b0;
        end else begin
            ack_o <= '0;
            case (state)
                S_IDLE: begin
                    busy_o <= 1'b0;
                    if (found) begin
                        grant_o      <= pick;
                        shift_data_o <= data_i[int'(pick)*WIDTH +: WIDTH];
                        busy_o       <= 1'b1;
                        shift_rdy_o  <= 1'b1;
                        state        <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    shift_rdy_o <= 1'b0;
                    cnt         <= CW'(SHIFT_CYCLES - 1);
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        ack_o <= N_REQ'(1) << grant_o;
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    last   <= grant_o;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftout_arbiter.sv
// Bench for shiftout_arbiter: vector table plus hand sequences, scoreboarded against
// a behavioural serializer and 595 latch fed from the arbiter's outputs.
module tb_shiftout_arbiter;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SC = 40;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   ack_o;
    logic           busy_o;
    logic [1:0]     grant_o;
    logic [W-1:0]   shift_data_o;
    logic           shift_rdy_o;

    shiftout_arbiter #(.WIDTH(W), .N_REQ(N), .GW(2), .SHIFT_CYCLES(SC)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .data_i(data_i),
        .ack_o(ack_o), .busy_o(busy_o), .grant_o(grant_o),
        .shift_data_o(shift_data_o), .shift_rdy_o(shift_rdy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Serializer + 595 model: 2 clocks per bit MSB first, then a latch pulse.
    logic         e_prev = 1'b0;
    logic         e_act = 1'b0;
    int           e_cnt = 0;
    logic [W-1:0] e_sh = '0;
    logic [W-1:0] q595 = '0;
    logic [W-1:0] latch_q = '0;
    int           latch_cnt = 0;

    always @(posedge clk) begin
        e_prev <= shift_rdy_o;
        if (reset_i) begin
            e_act <= 1'b0;
        end else if (shift_rdy_o === 1'b1 && e_prev !== 1'b1) begin
            e_act <= 1'b1;
            e_cnt <= 0;
            e_sh  <= shift_data_o;
        end else if (e_act) begin
            e_cnt <= e_cnt + 1;
            if (e_cnt < 2*W && e_cnt % 2 == 1) begin
                q595 <= {q595[W-2:0], e_sh[W-1]};
                e_sh <= e_sh << 1;
            end
            if (e_cnt == 2*W) begin
                latch_q   <= q595;
                latch_cnt <= latch_cnt + 1;
                e_act     <= 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [1:0]   g;
        logic [W-1:0] d;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: every strobe pops an expected grant; every ack is checked against it.
    int   cyc = 0, strobe_cyc = 0, last_strobe = 0, latch_base = 0, ack_total = 0;
    logic pending = 1'b0, have_strobe = 1'b0;
    exp_t cur = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset_i === 1'b1) begin
            pending     = 1'b0;
            have_strobe = 1'b0;
        end else begin
            if (shift_rdy_o === 1'b1) begin
                chk("strobe_while_pending", pending, 0);
                if (have_strobe) chk("strobe_spacing", (cyc - last_strobe) >= SC + 3, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant", grant_o, cur.g);
                    chk("shift_data", shift_data_o, cur.d);
                    chk("busy_at_strobe", busy_o, 1);
                    pending    = 1'b1;
                    strobe_cyc = cyc;
                    latch_base = latch_cnt;
                end
                last_strobe = cyc;
                have_strobe = 1'b1;
            end
            if ((|ack_o) === 1'b1) begin
                chk("ack_pending", pending, 1);
                chk("ack_onehot", ack_o, 4'b1 << cur.g);
                chk("ack_latency", cyc - strobe_cyc, SC + 1);
                chk("busy_at_ack", busy_o, 1);
                chk("latch_before_ack", latch_cnt - latch_base, 1);
                chk("latch_word", latch_q, cur.d);
                pending = 1'b0;
                ack_total++;
            end else if (pending && busy_o !== 1'b1) begin
                chk("busy_during_xfer", busy_o, 1);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        req_i   = '0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        chk("rst_ack", ack_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_data", shift_data_o, 0);
        chk("rst_rdy", shift_rdy_o, 0);
    endtask

    task automatic run_xfers(input logic [N-1:0] req, input logic [N-1:0] drop, input int n,
                             input logic [3:0][1:0] g, input logic [3:0][W-1:0] w);
        int acks = 0;
        int budget = n * (SC + 3) + 20;
        data_i = w;
        for (int k = 0; k < n; k++) exp_q.push_back({g[k], w[g[k]]});
        req_i = req;
        while (acks < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if ((|ack_o) === 1'b1) begin
                acks++;
                req_i = req_i & ~(ack_o & drop);
                if (acks == n) req_i = '0;
            end
        end
        chk("xfer_count", acks, n);
        chk("queue_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("busy_idle", busy_o, 0);
        exp_q.delete();
    endtask

    typedef struct packed {
        logic [N-1:0]      req;
        logic [N-1:0]      drop;
        logic [2:0]        n;
        logic [3:0][1:0]   g;
        logic [3:0][W-1:0] w;
    } vec_t;
    vec_t vt[5];

    initial begin
        int  b;
        bit  held;
        int  ack_before;

        // {req, drop-on-ack, count, grants (idx3..0), words (idx3..0)}
        vt[0] = {4'b0001, 4'b0001, 3'd1, {2'd0, 2'd0, 2'd0, 2'd0}, {16'h0, 16'h0, 16'h0, 16'hA5C3}};
        vt[1] = {4'b1111, 4'b1111, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
        vt[2] = {4'b0101, 4'b0000, 3'd4, {2'd2, 2'd0, 2'd2, 2'd0}, {16'h0, 16'h5A5A, 16'h0, 16'h0F0F}};
        vt[3] = {4'b1010, 4'b1010, 3'd2, {2'd0, 2'd0, 2'd3, 2'd1}, {16'hC001, 16'h0, 16'h8000, 16'h0}};
        vt[4] = {4'b1000, 4'b1000, 3'd1, {2'd0, 2'd0, 2'd0, 2'd3}, {16'hFFFF, 16'h1, 16'h2, 16'h3}};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            run_xfers(vt[v].req, vt[v].drop, int'(vt[v].n), vt[v].g, vt[v].w);
        end

        // Word in flight is unaffected by data_i/req_i changes; early drop still acks.
        do_reset();
        data_i = {16'h0, 16'h0, 16'hBEEF, 16'h0};
        exp_q.push_back({2'd1, 16'hBEEF});
        req_i = 4'b0010;
        b = 0;
        while (shift_rdy_o !== 1'b1 && b < 10) begin @(negedge clk); b++; end
        chk("hold_strobe_seen", shift_rdy_o, 1);
        repeat (5) @(negedge clk);
        data_i[W +: W] = 16'h0000;
        req_i = '0;
        held = 1'b1;
        b = 0;
        while ((|ack_o) !== 1'b1 && b < SC + 10) begin
            if (shift_data_o !== 16'hBEEF) held = 1'b0;
            @(negedge clk);
            b++;
        end
        chk("hold_ack_seen", |ack_o, 1);
        chk("hold_data_stable", held, 1);
        chk("hold_data_at_ack", shift_data_o, 16'hBEEF);

        // Reset ten cycles into WAIT aborts without ack; pointer returns to N-1.
        do_reset();
        data_i = {16'h0, 16'h0, 16'h0, 16'h1234};
        exp_q.push_back({2'd0, 16'h1234});
        req_i = 4'b0001;
        b = 0;
        while (shift_rdy_o !== 1'b1 && b < 10) begin @(negedge clk); b++; end
        chk("abort_strobe_seen", shift_rdy_o, 1);
        req_i = '0;
        repeat (11) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        chk("abort_ack", ack_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_grant", grant_o, 0);
        chk("abort_data", shift_data_o, 0);
        chk("abort_rdy", shift_rdy_o, 0);
        ack_before = ack_total;
        repeat (SC + 5) @(negedge clk);
        chk("abort_no_ack", ack_total - ack_before, 0);
        run_xfers(4'b0110, 4'b0110, 2, {2'd0, 2'd0, 2'd2, 2'd1},
                  {16'h0, 16'h6666, 16'h7777, 16'h0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
